// File: rtl/freq_div_n_pkg.sv
// Shared counter-library definitions for the programmable divider.
// No logic; constants and state encoding only.
// No flow control.
package freq_div_n_pkg;

  localparam int FDIV_MIN_DIV = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fdiv_state_t;

endpackage

// File: rtl/fdiv_halfcycle_ext.sv
// Falling-edge half-cycle extender: stretches q_p by half a clk for odd divisors.
// Latency: q_n follows q_p on the next falling edge; clk_out is a pure OR of two flops.
// No flow control.
module fdiv_halfcycle_ext (
  input  logic clk,
  input  logic rst_n,
  input  logic q_p,
  input  logic odd,
  output logic clk_out
);

  logic q_n;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_n <= 1'b0;
    end else begin
      q_n <= q_p & odd;
    end
  end

  assign clk_out = q_p | q_n;

endmodule

// File: rtl/freq_div_n.sv
// Runtime-programmable 50% duty clock divider with clk-domain period tick.
// Latency: outputs rise on the first rising edge with go; settings apply only at period boundaries.
// No flow control; mid-period div/en changes wait for the last cycle of the period.
module freq_div_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  import freq_div_n_pkg::*;

  fdiv_state_t      state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] act_div, act_div_nxt;
  logic [WIDTH-1:0] cnt_inc;
  logic             q_p, q_p_nxt;
  logic             tick_nxt, running_nxt;
  logic             go, last;

  assign go      = en && (div >= WIDTH'(FDIV_MIN_DIV));
  assign last    = (cnt == act_div - WIDTH'(1));
  assign cnt_inc = cnt + WIDTH'(1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    act_div_nxt = act_div;
    q_p_nxt     = q_p;
    tick_nxt    = tick;
    running_nxt = running;
    case (state)
      IDLE: begin
        // Idle registers are pinned to their reset values, not just held.
        cnt_nxt     = '0;
        act_div_nxt = '0;
        q_p_nxt     = 1'b0;
        tick_nxt    = 1'b0;
        running_nxt = 1'b0;
        if (go) begin
          state_nxt   = RUN;
          act_div_nxt = div;
          q_p_nxt     = 1'b1;
          tick_nxt    = 1'b1;
          running_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!last) begin
          cnt_nxt  = cnt_inc;
          tick_nxt = 1'b0;
          q_p_nxt  = (cnt_inc < (act_div >> 1));
        end else if (go) begin
          act_div_nxt = div;
          cnt_nxt     = '0;
          q_p_nxt     = 1'b1;
          tick_nxt    = 1'b1;
          running_nxt = 1'b1;
        end else begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          act_div_nxt = '0;
          q_p_nxt     = 1'b0;
          tick_nxt    = 1'b0;
          running_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      act_div <= '0;
      q_p     <= 1'b0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      act_div <= act_div_nxt;
      q_p     <= q_p_nxt;
      tick    <= tick_nxt;
      running <= running_nxt;
    end
  end

  assign cur_div = act_div;

  // Odd divisors borrow half a clk from the falling edge to reach 50% duty.
  fdiv_halfcycle_ext u_halfcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .q_p     (q_p),
    .odd     (act_div[0]),
    .clk_out (clk_out)
  );

endmodule

// File: doc/freq_div_n.md
# freq_div_n

Runtime-programmable clock divider with 50% duty cycle for both odd and even divisors. It divides `clk` by a divisor N (2 ≤ N ≤ 2^WIDTH−1), applying divisor and enable changes only at period boundaries so `clk_out` never produces a runt pulse. It also emits a single-cycle `tick` strobe in the `clk` domain for logic that must stay synchronous to `clk`. It is the general replacement for the fixed divide-by-3 divider in the counter library.

## Interface
- `WIDTH`, default 8: width of the divisor and of the internal counter.
- `clk` input 1: source clock; the counter runs on the rising edge, the odd-duty flop on the falling edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run request; sampled on rising edges.
- `div` input WIDTH: requested divisor N; values 0 and 1 are illegal and treated as "do not start".
- `clk_out` output 1: divided clock.
- `tick` output 1: one-`clk` pulse on the cycle in which each `clk_out` period starts.
- `running` output 1: high while a period is in progress.
- `cur_div` output WIDTH: divisor of the period in progress; 0 when idle.

## Operation
- State IDLE/RUN. Registers:
  - `cnt[WIDTH-1:0]`
  - `act_div` (drives `cur_div`)
  - `q_p` (posedge flop)
  - `q_n` (negedge flop)
  - `tick`
  - `running`
- Start condition `go = en && (div >= 2)`.
- IDLE, rising edge with `go`:
  - `act_div <= div`, `cnt <= 0`, `q_p <= 1`, `tick <= 1`, `running <= 1`.
  - State goes to RUN.
- IDLE without `go`: all registers hold their reset values.
- RUN, `cnt != act_div-1`:
  - `cnt <= cnt+1`, `tick <= 0`.
  - `q_p <= (cnt+1 < act_div>>1)`.
- RUN, `cnt == act_div-1` (last cycle of the period):
  - If `go`, start a new period as in IDLE, reloading `act_div` from `div`.
  - Otherwise `q_p <= 0`, `tick <= 0`, `running <= 0`, `act_div <= 0`, and state goes to IDLE.
- Negedge flop: `q_n <= q_p & act_div[0]`.
- `clk_out = q_p | q_n`, an OR of two flops, with no other combinational term.
- Even N: high for N/2 cycles, low for N/2 cycles.
- Odd N: high for (N−1)/2 + ½ = N/2 cycles, low for N/2 cycles.
- `div` and `en` changes in mid-period are ignored until the last cycle of the period.
- Rule on that last cycle: an illegal `div` while `en=1` stops the divider, exactly like `en=0`.
- Counter arithmetic is WIDTH bits. `cnt` never exceeds `act_div-1`, so it never wraps.

## Timing
- Reset (asynchronous, immediate): `cnt=0`, `act_div=0`, `q_p=0`, `q_n=0`, `tick=0`, `running=0`, so `clk_out=0`, `cur_div=0`.
- Reset asserted mid-period: `clk_out` falls without waiting for a clock edge. Release with `en=1` restarts on the first rising edge after release.
- Start latency: `clk_out`, `tick` and `running` rise on the first rising edge at which `go` is sampled high.
- Period N: `clk_out` and `tick` rise on the same rising edge every N `clk` cycles.
- Back-to-back periods: no gap, and `tick` pulses each period.
- Stop: after the final period ends, `clk_out` remains low. `running` falls on the rising edge that would have started the next period.
- Falling edges of `clk_out`:
  - Even N: on a rising edge of `clk`.
  - Odd N: on a falling edge of `clk`.

## Structure
- Shared counter-library package: `FDIV_MIN_DIV = 2`, and the state enum `fdiv_state_t` {IDLE, RUN}.
- Sub-module `fdiv_halfcycle_ext`: the negedge `q_n` flop with asynchronous reset plus the OR gate. It isolates the dual-edge logic for timing constraints.
- Everything else stays in `freq_div_n`.

## Test plan
- `div=4`, `en=1` after reset → `clk_out` period 4 cycles, high 2 / low 2. `tick` high 1 of every 4 cycles, coincident with the `clk_out` rise. `cur_div=4`.
- `div=3` → `clk_out` period 3 cycles, high 1.5 cycles, with the fall on a `clk` negedge. Same check for `div=255` with `WIDTH=8`.
- Running at `div=4`, change `div` to 5 at `cnt=1` → current period completes at 4 cycles, next period is 5. `cur_div` changes exactly at the new `tick`.
- Running at `div=6`, drop `en` at `cnt=2` → `clk_out` completes its 3-high/3-low period, then stays low. `running` falls 6 cycles after the last `tick`.
- `en=1` with `div=0`, then `div=1` → `clk_out`, `tick` and `running` stay 0. Setting `div=2` starts on the next rising edge with a period of 2 cycles.
- Assert `rst_n=0` while `clk_out` is high (`div=7`) → `clk_out`, `running` and `cur_div` go to 0 immediately. After release with `en=1`, the period restarts cleanly with no runt pulse.
